simmem_release_scheduler: RTL



---
 rtl/simmem_pkg.sv | 14 +
 rtl/simmem_delay_tracker.sv | 57 +++++
 rtl/simmem_release_scheduler.sv | 105 ++++++++++
 3 files changed

// File: rtl/simmem_pkg.sv
// Shared types and constants for the simulated-memory response scheduler.
// Imported by simmem_delay_tracker and simmem_release_scheduler.
package simmem_pkg;

  typedef enum logic [1:0] {
    TrkIdle,
    TrkWait,
    TrkElig
  } tracker_state_e;

  localparam int unsigned DefaultDelayWidth = 8;
  localparam int unsigned StatsWidth = 32;

endpackage

// File: rtl/simmem_delay_tracker.sv
// One per-ID head tracker: counts down the programmed delay after a head
// appears, then holds eligible until the head is popped or disappears.
module simmem_delay_tracker
  import simmem_pkg::*;
#(
  parameter int unsigned DelayWidth = DefaultDelayWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  head_valid_i,
  input  logic [DelayWidth-1:0] delay_i,
  input  logic                  pop_i,
  output logic                  eligible_o
);

  tracker_state_e        state_q, state_d;
  logic [DelayWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      TrkIdle: begin
        if (head_valid_i) begin
          cnt_d   = delay_i;
          state_d = (delay_i == '0) ? TrkElig : TrkWait;
        end
      end
      TrkWait: begin
        // A vanished head is a protocol error; just drop back to idle.
        if (!head_valid_i) begin
          state_d = TrkIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DelayWidth'(1)) state_d = TrkElig;
        end
      end
      TrkElig: begin
        if (pop_i || !head_valid_i) state_d = TrkIdle;
      end
      default: state_d = TrkIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TrkIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign eligible_o = (state_q == TrkElig);

endmodule

// File: rtl/simmem_release_scheduler.sv
// Delayed-release round-robin scheduler over NumIds response queues.
// Optional counters enabled by defining SIMMEM_SCHED_STATS_EN.
module simmem_release_scheduler
  import simmem_pkg::*;
#(
  parameter int unsigned NumIds     = 4,
  parameter int unsigned IdWidth    = $clog2(NumIds),
  parameter int unsigned DelayWidth = DefaultDelayWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumIds-1:0]            head_valid_i,
  input  logic [NumIds*DelayWidth-1:0] delay_i,
  output logic [NumIds-1:0]            head_pop_o,
  output logic                         grant_valid_o,
  output logic [IdWidth-1:0]           grant_id_o,
  input  logic                         grant_ready_i,
  output logic [StatsWidth-1:0]        grants_total_o,
  output logic [StatsWidth-1:0]        stall_cycles_o
);

  logic [NumIds-1:0]  elig;
  logic [IdWidth-1:0] rr_q;
  logic [IdWidth-1:0] lock_id_q;
  logic               lock_q;
  logic [IdWidth-1:0] scan_id;
  logic               scan_hit;
  logic               xfer;
  logic [IdWidth-1:0] rr_next;

  for (genvar g = 0; g < NumIds; g++) begin : g_trk
    simmem_delay_tracker #(
      .DelayWidth(DelayWidth)
    ) u_trk (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .head_valid_i(head_valid_i[g]),
      .delay_i     (delay_i[g*DelayWidth +: DelayWidth]),
      .pop_i       (head_pop_o[g]),
      .eligible_o  (elig[g])
    );
  end

  // First eligible index at or after rr_q, wrapping.
  always_comb begin
    scan_id  = '0;
    scan_hit = 1'b0;
    for (int unsigned k = 0; k < NumIds; k++) begin
      int unsigned j;
      j = (32'(rr_q) + k) % NumIds;
      if (!scan_hit && elig[IdWidth'(j)]) begin
        scan_hit = 1'b1;
        scan_id  = IdWidth'(j);
      end
    end
  end

  assign grant_valid_o = lock_q | (|elig);
  assign grant_id_o    = lock_q ? lock_id_q : scan_id;
  assign xfer          = grant_valid_o & grant_ready_i;

  assign rr_next = (grant_id_o == IdWidth'(NumIds - 1)) ?
                   '0 : grant_id_o + 1'b1;

  always_comb begin
    head_pop_o = '0;
    if (xfer) head_pop_o[grant_id_o] = 1'b1;
  end

  // Lock holds the presented ID stable across backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      rr_q      <= '0;
    end else if (xfer) begin
      lock_q <= 1'b0;
      rr_q   <= rr_next;
    end else if (grant_valid_o) begin
      lock_q    <= 1'b1;
      lock_id_q <= grant_id_o;
    end
  end

`ifdef SIMMEM_SCHED_STATS_EN
  logic [StatsWidth-1:0] grants_q, stalls_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      if (xfer) grants_q <= grants_q + 1'b1;
      if (grant_valid_o && !grant_ready_i) stalls_q <= stalls_q + 1'b1;
    end
  end

  assign grants_total_o = grants_q;
  assign stall_cycles_o = stalls_q;
`else
  assign grants_total_o = '0;
  assign stall_cycles_o = '0;
`endif

endmodule
